// File: rtl/mcpu_if.sv
// mcpu_if: shared instruction/data MIO bus between the
// core (master) and the bus bridge or memory (slave).
interface mcpu_if;
  logic [31:0] Data_in;
  logic [31:0] Addr_out;
  logic [31:0] Data_out;
  logic        MIO_ready;
  logic        mem_w;
  logic        CPU_MIO;

  modport master (
    input  Data_in, MIO_ready,
    output Addr_out, Data_out, mem_w, CPU_MIO
  );

  modport slave (
    output Data_in, MIO_ready,
    input  Addr_out, Data_out, mem_w, CPU_MIO
  );
endinterface

// File: rtl/mcpu.sv
// mcpu: multi-cycle MIPS-subset core on one shared,
// variable-latency MIO bus, with vectored interrupt and eret.
module mcpu #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] INT_VECTOR = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        INT,
  mcpu_if.master      bus,
  output logic [31:0] PC_out,
  output logic [2:0]  state_out
);
  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_INT = 3'd5
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0a;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  localparam logic [31:0] ERET = 32'h4200_0018;

  state_t state, state_nx;

  logic [31:0] pc, ir, a, b, alu_out, mdr, epc;
  logic        ie;
  logic [31:0] rf [32];

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sx, zx, opb, alu_y;
  logic [31:0] rs_val, rt_val, j_tgt;

  assign op = ir[31:26];
  assign fn = ir[5:0];
  assign rs = ir[25:21];
  assign rt = ir[20:16];
  assign rd = ir[15:11];
  assign sx = {{16{ir[15]}}, ir[15:0]};
  assign zx = {16'h0000, ir[15:0]};
  assign j_tgt = {pc[31:28], ir[25:0], 2'b00};

  assign rs_val = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 : rf[rt];

  logic is_r, is_jr, r_alu, i_alu;
  logic is_lw, is_sw, is_beq, is_bne;
  logic is_j, is_jal, is_eret, to_ex;
  logic f_add, f_sub, f_and, f_or;
  logic f_nor, f_slt, f_lui;
  logic take_int, br_take;

  assign is_r    = op == OP_R;
  assign is_jr   = is_r && fn == FN_JR;
  assign is_lw   = op == OP_LW;
  assign is_sw   = op == OP_SW;
  assign is_beq  = op == OP_BEQ;
  assign is_bne  = op == OP_BNE;
  assign is_j    = op == OP_J;
  assign is_jal  = op == OP_JAL;
  assign is_eret = ir == ERET;

  assign f_add = (is_r && (fn == FN_ADD || fn == FN_ADDU))
              || op == OP_ADDI || is_lw || is_sw;
  assign f_sub = is_r && (fn == FN_SUB || fn == FN_SUBU);
  assign f_and = (is_r && fn == FN_AND) || op == OP_ANDI;
  assign f_or  = (is_r && fn == FN_OR) || op == OP_ORI;
  assign f_nor = is_r && fn == FN_NOR;
  assign f_slt = (is_r && fn == FN_SLT) || op == OP_SLTI;
  assign f_lui = op == OP_LUI;

  assign r_alu = is_r && (f_add || f_sub || f_and
              || f_or || f_nor || f_slt);
  assign i_alu = op == OP_ADDI || op == OP_ANDI
              || op == OP_ORI || op == OP_SLTI || f_lui;
  assign to_ex = r_alu || i_alu || is_lw || is_sw
              || is_beq || is_bne;

  assign take_int = state == S_IF && INT && ie;
  assign br_take  = (is_beq && a == b) || (is_bne && a != b);

  // andi/ori zero-extend; every other immediate sign-extends
  assign opb = is_r ? b
             : (op == OP_ANDI || op == OP_ORI) ? zx : sx;

  always_comb begin
    alu_y = '0;
    unique case (1'b1)
      f_add:   alu_y = a + opb;
      f_sub:   alu_y = a - opb;
      f_and:   alu_y = a & opb;
      f_or:    alu_y = a | opb;
      f_nor:   alu_y = ~(a | opb);
      f_slt:   alu_y = {31'd0, $signed(a) < $signed(opb)};
      f_lui:   alu_y = {ir[15:0], 16'h0000};
      default: alu_y = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IF;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    bus.CPU_MIO  = 1'b0;
    bus.mem_w    = 1'b0;
    bus.Addr_out = '0;
    bus.Data_out = '0;
    unique case (state)
      S_IF: begin
        if (take_int) begin
          state_nx = S_INT;
        end else begin
          bus.CPU_MIO  = 1'b1;
          bus.Addr_out = pc;
          if (bus.MIO_ready) state_nx = S_ID;
        end
      end
      S_ID: state_nx = to_ex ? S_EX : S_IF;
      S_EX: begin
        if (is_lw || is_sw)        state_nx = S_MEM;
        else if (is_beq || is_bne) state_nx = S_IF;
        else                       state_nx = S_WB;
      end
      S_MEM: begin
        bus.CPU_MIO  = 1'b1;
        bus.Addr_out = alu_out;
        bus.mem_w    = is_sw;
        bus.Data_out = is_sw ? b : '0;
        if (bus.MIO_ready) state_nx = is_lw ? S_WB : S_IF;
      end
      S_WB:    state_nx = S_IF;
      S_INT:   state_nx = S_IF;
      default: state_nx = S_IF;
    endcase
    // reset abandons any bus transaction immediately
    if (reset) begin
      bus.CPU_MIO  = 1'b0;
      bus.mem_w    = 1'b0;
      bus.Addr_out = '0;
      bus.Data_out = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      epc     <= '0;
      ie      <= 1'b1;
    end else begin
      unique case (state)
        S_IF: begin
          if (!take_int && bus.MIO_ready) begin
            ir <= bus.Data_in;
            pc <= pc + 32'd4;
          end
        end
        S_ID: begin
          a       <= rs_val;
          b       <= rt_val;
          alu_out <= pc + {sx[29:0], 2'b00};
          unique case (1'b1)
            is_j, is_jal: pc <= j_tgt;
            is_jr:        pc <= rs_val;
            is_eret: begin
              pc <= epc;
              ie <= 1'b1;
            end
            default: ;
          endcase
        end
        S_EX: begin
          if (r_alu || i_alu || is_lw || is_sw)
            alu_out <= alu_y;
          if (br_take) pc <= alu_out;
        end
        S_MEM: begin
          if (is_lw && bus.MIO_ready) mdr <= bus.Data_in;
        end
        S_INT: begin
          epc <= pc;
          pc  <= INT_VECTOR;
          ie  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  // jal links in ID, where pc already holds its PC+4
  always_comb begin
    rf_we = 1'b0;
    rf_wa = '0;
    rf_wd = '0;
    if (state == S_ID && is_jal) begin
      rf_we = 1'b1;
      rf_wa = 5'd31;
      rf_wd = pc;
    end else if (state == S_WB) begin
      rf_we = 1'b1;
      rf_wa = is_r ? rd : rt;
      rf_wd = is_lw ? mdr : alu_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && rf_we && rf_wa != 5'd0)
      rf[rf_wa] <= rf_wd;
  end

  assign PC_out    = pc;
  assign state_out = state;
endmodule

// File: tb/tb_mcpu.sv
// tb_mcpu: directed bus/branch/interrupt/reset cases, then random
// programs checked against an instruction-level model.
`timescale 1ns/1ps
module tb_mcpu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        intr = 1'b0;
  logic        rdy = 1'b1;
  logic [31:0] pc_out;
  logic [2:0]  st;

  mcpu_if bus();

  mcpu dut (
    .clk       (clk),
    .reset     (reset),
    .INT       (intr),
    .bus       (bus),
    .PC_out    (pc_out),
    .state_out (st)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];

  assign bus.Data_in   = mem[bus.Addr_out[9:2]];
  assign bus.MIO_ready = rdy;

  always @(posedge clk)
    if (bus.CPU_MIO && bus.mem_w && bus.MIO_ready)
      mem[bus.Addr_out[9:2]] <= bus.Data_out;

  int checks = 0;
  int errors = 0;
  int cy;

  localparam logic [31:0] LOOP = 32'h1000_ffff;
  localparam logic [31:0] ERET = 32'h4200_0018;
  localparam int          ENDW = 60;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(logic [4:0] s,
      logic [4:0] t, logic [4:0] d, logic [5:0] f);
    return {6'h00, s, t, d, 5'h00, f};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] o,
      logic [4:0] s, logic [4:0] t, logic [15:0] im);
    return {o, s, t, im};
  endfunction

  function automatic logic [31:0] jtype(logic [5:0] o,
      logic [25:0] tg);
    return {o, tg};
  endfunction

  task automatic clr_mem();
    for (int k = 0; k < 256; k++) mem[k] = 32'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rdy   = 1'b1;
    intr  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mio",  {31'd0, bus.CPU_MIO}, 32'd0);
    chk("rst_memw", {31'd0, bus.mem_w}, 32'd0);
    chk("rst_addr", bus.Addr_out, 32'd0);
    chk("rst_st",   {29'd0, st}, 32'd0);
    chk("rst_pc",   pc_out, 32'd0);
    reset = 1'b0;
    #1;
    chk("if0_addr", bus.Addr_out, 32'd0);
    chk("if0_mio",  {31'd0, bus.CPU_MIO}, 32'd1);
    cy = 1;
  endtask

  task automatic adv(int k);
    while (cy < k) begin
      @(negedge clk);
      cy++;
    end
  endtask

  // instruction-level reference model
  logic [31:0] m_r   [32];
  logic        m_wr  [32];
  logic [31:0] m_mem [256];
  logic [31:0] m_pc;
  logic [4:0]  m_wa;
  int          m_cpi;

  task automatic m_step();
    logic [31:0] i, x, y, s, z, np, v, ea;
    logic [5:0]  o, f;
    logic [4:0]  d;
    i  = m_mem[m_pc[9:2]];
    o  = i[31:26];
    f  = i[5:0];
    x  = m_r[i[25:21]];
    y  = m_r[i[20:16]];
    s  = {{16{i[15]}}, i[15:0]};
    z  = {16'h0000, i[15:0]};
    np = m_pc + 32'd4;
    d  = 5'd0;
    v  = 32'd0;
    ea = x + s;
    m_cpi = 4;
    case (o)
      6'h00: begin
        d = i[15:11];
        case (f)
          6'h20, 6'h21: v = x + y;
          6'h22, 6'h23: v = x - y;
          6'h24: v = x & y;
          6'h25: v = x | y;
          6'h27: v = ~(x | y);
          6'h2a: v = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
          6'h08: begin np = x; d = 5'd0; m_cpi = 2; end
          default: begin d = 5'd0; m_cpi = 2; end
        endcase
      end
      6'h08: begin d = i[20:16]; v = x + s; end
      6'h0c: begin d = i[20:16]; v = x & z; end
      6'h0d: begin d = i[20:16]; v = x | z; end
      6'h0a: begin
        d = i[20:16];
        v = ($signed(x) < $signed(s)) ? 32'd1 : 32'd0;
      end
      6'h0f: begin d = i[20:16]; v = {i[15:0], 16'h0000}; end
      6'h23: begin d = i[20:16]; v = m_mem[ea[9:2]]; m_cpi = 5; end
      6'h2b: m_mem[ea[9:2]] = y;
      6'h04: begin m_cpi = 3; if (x == y) np = np + (s << 2); end
      6'h05: begin m_cpi = 3; if (x != y) np = np + (s << 2); end
      6'h02: begin m_cpi = 2; np = {np[31:28], i[25:0], 2'b00}; end
      6'h03: begin
        m_cpi = 2;
        d = 5'd31;
        v = np;
        np = {np[31:28], i[25:0], 2'b00};
      end
      default: m_cpi = 2;
    endcase
    if (d != 5'd0) begin
      m_r[d]  = v;
      m_wr[d] = 1'b1;
    end
    m_wa = d;
    m_pc = np;
  endtask

  logic [5:0] fns [8] = '{6'h20, 6'h21, 6'h22, 6'h23,
                          6'h24, 6'h25, 6'h27, 6'h2a};
  logic [5:0] iops [5] = '{6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h0f};

  task automatic gen_prog();
    logic [4:0]  s, t, d;
    logic [15:0] im;
    int          mx, off;
    clr_mem();
    for (int k = 128; k < 192; k++) mem[k] = $urandom;
    for (int r = 1; r < 8; r++)
      mem[r-1] = itype(6'h08, 5'd0, 5'(r), 16'($urandom));
    for (int k = 7; k < ENDW; k++) begin
      s   = 5'($urandom_range(0, 7));
      t   = 5'($urandom_range(0, 7));
      d   = 5'($urandom_range(0, 7));
      im  = 16'($urandom);
      mx  = (ENDW - 1 - k) < 3 ? (ENDW - 1 - k) : 3;
      off = $urandom_range(0, mx);
      case ($urandom_range(0, 11))
        0, 1, 2: mem[k] = rtype(s, t, d, fns[$urandom_range(0, 7)]);
        3, 4:    mem[k] = itype(iops[$urandom_range(0, 4)], s, t, im);
        5: mem[k] = itype(6'h23, 5'd0, t,
                          16'(32'h200 + 4 * $urandom_range(0, 63)));
        6: mem[k] = itype(6'h2b, 5'd0, t,
                          16'(32'h200 + 4 * $urandom_range(0, 63)));
        7:  mem[k] = itype(6'h04, s, t, 16'(off));
        8:  mem[k] = itype(6'h05, s, t, 16'(off));
        9:  mem[k] = jtype(6'h02, 26'(k + 1 + off));
        10: mem[k] = jtype(6'h03, 26'(k + 1 + off));
        default: mem[k] = ($urandom_range(0, 1) != 0)
                          ? 32'hfc00_0000 : rtype(s, t, d, 6'h3f);
      endcase
    end
    mem[ENDW] = LOOP;
    for (int k = 0; k < 256; k++) m_mem[k] = mem[k];
  endtask

  task automatic run_rand();
    logic [2:0] prv;
    int         cyc, stl, extra;
    bit         first;
    gen_prog();
    for (int r = 0; r < 32; r++) begin
      m_r[r]  = 32'd0;
      m_wr[r] = 1'b0;
    end
    m_pc  = 32'd0;
    do_reset();
    prv   = 3'd7;
    first = 1'b1;
    cyc   = 0;
    stl   = 0;
    extra = 0;
    for (int n = 0; n < 20000 && extra < 3; n++) begin
      if (st == 3'd0 && prv != 3'd0) begin
        if (!first) begin
          m_step();
          chk("r_pc", pc_out, m_pc);
          chk("r_cpi", cyc, m_cpi + stl);
          if (m_wa != 5'd0)
            chk("r_rf", dut.rf[m_wa], m_r[m_wa]);
          if (m_pc == 32'(ENDW * 4)) extra++;
        end
        first = 1'b0;
        cyc   = 0;
        stl   = 0;
      end
      prv = st;
      rdy = $urandom_range(0, 3) != 0;
      cyc++;
      if (bus.CPU_MIO && !rdy) stl++;
      @(negedge clk);
    end
    chk("r_end", extra, 3);
    for (int r = 1; r < 32; r++)
      if (m_wr[r]) chk("r_reg", dut.rf[r], m_r[r]);
    for (int k = 128; k < 192; k++)
      chk("r_mem", mem[k], m_mem[k]);
  endtask

  logic [10:0] sch;
  int          nw;

  initial begin
    // addi after reset
    clr_mem();
    mem[0] = itype(6'h08, 5'd0, 5'd1, 16'd5);
    mem[1] = LOOP;
    do_reset();
    adv(5);
    chk("addi_rf", dut.rf[1], 32'd5);
    chk("addi_pc", pc_out, 32'd4);
    chk("addi_st", {29'd0, st}, 32'd0);

    // lw with three wait cycles on fetch and on data
    clr_mem();
    mem[0] = itype(6'h23, 5'd0, 5'd2, 16'd8);
    mem[1] = LOOP;
    mem[2] = 32'hdead_beef;
    sch = 11'b11000111000;
    do_reset();
    for (int c = 1; c <= 11; c++) begin
      adv(c);
      rdy = sch[c-1];
      if (c <= 4) chk("lw_faddr", bus.Addr_out, 32'd0);
      if (c >= 7 && c <= 10) chk("lw_daddr", bus.Addr_out, 32'd8);
      if (c == 2 || c == 8) chk("lw_mio", {31'd0, bus.CPU_MIO}, 32'd1);
      if (c == 8) chk("lw_memw", {31'd0, bus.mem_w}, 32'd0);
    end
    chk("lw_wb", {29'd0, st}, 32'd4);
    adv(12);
    rdy = 1'b1;
    chk("lw_st", {29'd0, st}, 32'd0);
    chk("lw_rf", dut.rf[2], 32'hdead_beef);
    chk("lw_pc", pc_out, 32'd4);

    // store
    clr_mem();
    mem[0] = itype(6'h0f, 5'd0, 5'd3, 16'h1234);
    mem[1] = itype(6'h0d, 5'd3, 5'd3, 16'h5678);
    mem[2] = itype(6'h2b, 5'd0, 5'd3, 16'd16);
    mem[3] = LOOP;
    nw = 0;
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      adv(c);
      if (bus.mem_w) begin
        nw++;
        chk("sw_addr", bus.Addr_out, 32'd16);
        chk("sw_data", bus.Data_out, 32'h1234_5678);
        chk("sw_cyc", cy, 12);
      end
      if (c == 13) chk("sw_ret", {29'd0, st}, 32'd0);
    end
    chk("sw_cnt", nw, 1);
    chk("sw_mem", mem[4], 32'h1234_5678);

    // j, jal, jr, beq loop
    clr_mem();
    mem[0]  = jtype(6'h02, 26'd16);
    mem[16] = jtype(6'h03, 26'd24);
    mem[17] = LOOP;
    mem[24] = rtype(5'd31, 5'd0, 5'd0, 6'h08);
    do_reset();
    adv(3);
    chk("j_pc", pc_out, 32'h40);
    adv(5);
    chk("jal_pc", pc_out, 32'h60);
    chk("jal_rf", dut.rf[31], 32'h44);
    adv(7);
    chk("jr_pc", pc_out, 32'h44);
    adv(8);
    chk("beq_if", pc_out, 32'h48);
    adv(10);
    chk("beq_pc1", pc_out, 32'h44);
    chk("beq_st", {29'd0, st}, 32'd0);
    adv(13);
    chk("beq_pc2", pc_out, 32'h44);

    // interrupt raised during EX of add at 0x20
    clr_mem();
    mem[0] = jtype(6'h02, 26'd6);
    mem[1] = ERET;
    mem[6] = itype(6'h08, 5'd0, 5'd1, 16'd7);
    mem[8] = rtype(5'd1, 5'd1, 5'd5, 6'h20);
    mem[9] = LOOP;
    do_reset();
    adv(11);
    chk("int_ex", {29'd0, st}, 32'd2);
    intr = 1'b1;
    adv(12);
    chk("int_wb", {29'd0, st}, 32'd4);
    adv(13);
    chk("int_if", {29'd0, st}, 32'd0);
    chk("int_nof", {31'd0, bus.CPU_MIO}, 32'd0);
    chk("int_add", dut.rf[5], 32'd14);
    adv(14);
    chk("int_st", {29'd0, st}, 32'd5);
    adv(15);
    chk("int_pc", pc_out, 32'd4);
    chk("int_epc", dut.epc, 32'h24);
    chk("int_ie", {31'd0, dut.ie}, 32'd0);
    chk("int_mask", {31'd0, bus.CPU_MIO}, 32'd1);
    adv(16);
    chk("eret_id", {29'd0, st}, 32'd1);
    intr = 1'b0;
    adv(17);
    chk("eret_pc", pc_out, 32'h24);
    chk("eret_ie", {31'd0, dut.ie}, 32'd1);

    // reset during MEM wait of sw
    clr_mem();
    mem[0] = itype(6'h08, 5'd0, 5'd3, 16'h0055);
    mem[1] = itype(6'h2b, 5'd0, 5'd3, 16'd16);
    mem[2] = LOOP;
    do_reset();
    adv(8);
    rdy = 1'b0;
    chk("rsw_mem", {29'd0, st}, 32'd3);
    chk("rsw_w", {31'd0, bus.mem_w}, 32'd1);
    adv(9);
    chk("rsw_wait", bus.Addr_out, 32'd16);
    reset = 1'b1;
    rdy   = 1'b1;
    #1;
    chk("rsw_drop", {31'd0, bus.mem_w}, 32'd0);
    chk("rsw_mio", {31'd0, bus.CPU_MIO}, 32'd0);
    chk("rsw_addr", bus.Addr_out, 32'd0);
    adv(10);
    chk("rsw_st", {29'd0, st}, 32'd0);
    chk("rsw_pc", pc_out, 32'd0);
    chk("rsw_nowr", mem[4], 32'd0);
    reset = 1'b0;

    for (int p = 0; p < 3; p++) run_rand();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mcpu.md
# mcpu

Multi-cycle MIPS-subset CPU core that replaces the single-cycle core for systems with one unified, variable-latency memory bus. Instruction fetch and data access share one port, every bus transaction waits on `MIO_ready`, and a level-sensitive interrupt is vectored with EPC save and `eret` return. Sits between the board's MIO/bus bridge and memory/peripherals, with the same bus signal names as the existing core.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `INT_VECTOR`, 32'h0000_0004, PC loaded when an interrupt is taken
- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `Data_in`  in  32  read data from bus (instruction in IF, load data in MEM)
- `INT`  in  1  level interrupt request
- `MIO_ready`  in  1  bus completes the current transaction this cycle
- `PC_out`  out  32  architectural PC register
- `Addr_out`  out  32  bus address (PC in IF, ALUOut in MEM, else 0)
- `Data_out`  out  32  store data (register B), valid while `mem_w`=1
- `mem_w`  out  1  bus write strobe
- `CPU_MIO`  out  1  bus request; high for the whole transaction
- `state_out`  out  3  current FSM state, for debug

## Operation
- ISA: R-type add, addu, sub, subu, and, or, nor, slt, jr. I-type addi, andi, ori, slti, lui, lw, sw, beq, bne. J-type j, jal (writes $31 = PC+4). eret is 32'h4200_0018.
- Internal registers: PC, IR, A, B, ALUOut, MDR, EPC, IE. 32x32 register file with $0 reading as 0 and writes to it ignored.
- Extension: andi/ori zero-extend; all other immediates sign-extend. lui gives {imm,16'h0}. slt/slti are signed.
- Overflow does not trap (add behaves as addu).
- Unknown opcode/funct executes as a nop: ID -> IF, PC already advanced.
- States (encoding for `state_out`): IF=0, ID=1, EX=2, MEM=3, WB=4, INT=5.
- IF:
  - If INT&IE: `CPU_MIO`=0, go to INT.
  - Else: `CPU_MIO`=1, `Addr_out`=PC. Stay in IF until `MIO_ready`. On `MIO_ready`: IR<=Data_in, PC<=PC+4, go to ID.
- ID: A<=rs, B<=rt, ALUOut<=PC+(sext(imm)<<2).
  - j: PC<={PC[31:28],target,2'b00}, go to IF.
  - jal: same as j, plus $31<=PC. Note PC has already been incremented, so this is PC+4 of the jal.
  - jr: PC<=rs, go to IF.
  - eret: PC<=EPC, IE<=1, go to IF.
  - All other opcodes go to EX.
- EX:
  - R/I ALU ops: ALUOut<=result, go to WB.
  - lw/sw: ALUOut<=A+sext(imm), go to MEM.
  - beq/bne: if the condition holds, PC<=ALUOut. Go to IF.
- MEM:
  - `CPU_MIO`=1, `Addr_out`=ALUOut.
  - sw: `mem_w`=1, `Data_out`=B. Hold until `MIO_ready`, then go to IF.
  - lw: hold until `MIO_ready`, then MDR<=Data_in, go to WB.
- WB: write rd (R-type), or rt (I-type ALU ops, lw from MDR). Go to IF.
- INT: EPC<=PC, PC<=INT_VECTOR, IE<=0, go to IF.
  - Interrupts are only taken at instruction boundaries (IF entry), never mid-instruction.
  - Further interrupts stay masked until eret.
- Bus outputs are combinational from state. Outside IF/MEM: `CPU_MIO`=0, `mem_w`=0, `Addr_out`=0.

## Timing
- Reset (any state, including mid-transaction):
  - Next edge: PC=RESET_PC, state=IF, IE=1, EPC=0, IR/A/B/ALUOut/MDR=0.
  - Register file is not cleared.
  - While `reset`=1, `CPU_MIO`=`mem_w`=0 and `Addr_out`=0. A pending bus transaction is abandoned.
- Cycles per instruction with `MIO_ready` tied high:
  - j/jal/jr/eret/nop: 2
  - beq/bne: 3
  - ALU ops and sw: 4
  - lw: 5
  - Taken interrupt: +1 (INT state)
  - Each wait cycle of `MIO_ready`=0 in IF or MEM adds 1.
- `MIO_ready` is ignored outside IF/MEM. While waiting, `Addr_out`, `Data_out` and `mem_w` are held stable.
- PC+4 and branch target arithmetic wrap modulo 2^32.
- INT asserted exactly in an IF cycle with IE=1 is taken in that cycle. The fetch is suppressed, even if `MIO_ready`=1.
- INT rising during ID..WB is deferred to the next IF. INT deasserted before IF is not taken (level-sensitive, no latch).

## Test plan
- **Reset then fetch.** RESET_PC=0, memory with `MIO_ready`=1, word0=addi $1,$0,5. Release reset.
  - Required: first IF shows `Addr_out`=0 and `CPU_MIO`=1.
  - After 4 cycles $1=5 and `PC_out`=4.
- **Wait states.** Hold `MIO_ready`=0 for 3 cycles on both the lw fetch and the data access. Instruction: lw $2,8($0), mem[8]=32'hDEAD_BEEF.
  - Required: lw takes 11 cycles and $2=32'hDEAD_BEEF.
  - `Addr_out` is held at PC, then at 8, throughout each wait.
- **Store.** $3=32'h1234_5678, sw $3,16($0).
  - Required: exactly one MEM cycle with `mem_w`=1, `Addr_out`=16, `Data_out`=32'h1234_5678.
  - Return to IF on the next edge.
- **Branch and jump.**
  - beq $0,$0,-1 loops: PC returns to the beq address every 3 cycles.
  - jal at 0x40: $31=0x44.
  - jr $31 sets PC=0x44.
- **Interrupt.** Raise INT during the EX of an add at 0x20.
  - Required: the add completes (WB happens), then state INT, EPC=0x24, PC=INT_VECTOR, IE=0.
  - INT held high is not re-taken. eret sets PC=0x24 and IE=1.
- **Reset mid-transaction.** Assert `reset` during a MEM wait of sw.
  - Required: `mem_w` drops in that same cycle, state=IF, PC=RESET_PC, and no write completes.
